// File: rtl/MemoryController_Definitions.sv
// MemoryController_Definitions
//   Shared memory-controller constants and types used by the PHY write path.
//   MEM_DATAWIDTH : DQ bus width in bits
//   BURST_LENGTH  : beats per burst (power of two, >= 2)
//   PHYFIFODEPTH  : PHY write FIFO depth in beats (multiple of BURST_LENGTH)
//   phy_wr_state_t: write-mode transmitter FSM states
//   ERR_*         : bit positions within errFlags
package MemoryController_Definitions;

   localparam int unsigned MEM_DATAWIDTH = 64;
   localparam int unsigned BURST_LENGTH  = 8;
   localparam int unsigned PHYFIFODEPTH  = 16;

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      BURST,
      POSTAMBLE
   } phy_wr_state_t;

   localparam int unsigned ERR_LAUNCH = 0;
   localparam int unsigned ERR_LAST   = 1;

endpackage

// File: rtl/phy_write_fifo.sv
// phy_write_fifo
//   PHY-local beat FIFO between the Write Buffer and the DQ drivers.
//   clk, rst  : clock, asynchronous active-high reset
//   wr_data   : beat to store
//   wr_valid  : beat offered; stored when wr_ready is also high
//   wr_ready  : FIFO not full (combinational from occ)
//   rd_en     : pop the head beat
//   rd_data   : head beat (combinational read at rptr)
//   occ       : beats currently held
module phy_write_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   occ
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             wr_en;

   assign wr_ready = (occ != (AW+1)'(DEPTH));
   assign wr_en    = wr_valid & wr_ready;
   assign rd_data  = mem[rptr];

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         occ  <= '0;
      end else begin
         if (wr_en) wptr <= ptr_next(wptr);
         if (rd_en) rptr <= ptr_next(rptr);
         case ({wr_en, rd_en})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/phy_write_mode.sv
// phy_write_mode
//   PHY WRITE-mode transmitter: buffers burst-aligned write beats and, on a
//   launch pulse, drives one burst onto DQ with DQS preamble/toggle/postamble,
//   then pulses writeDataACK.
//   clk, rst          : clock, asynchronous active-high reset
//   inData/Valid/Last : write beats from the Write Buffer; inDataReady = FIFO not full
//   outflag           : single-cycle launch pulse
//   outData, outDataEnable, dqs_t, dqs_c : registered DQ/DQS drive
//   writeDataACK      : single-cycle pulse once a burst has been driven
//   burstAvail        : at least one complete, unreserved burst buffered
//   errFlags          : sticky; [0] launch underrun/overlap, [1] LAST misalignment
module phy_write_mode
   import MemoryController_Definitions::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [MEM_DATAWIDTH-1:0] inData,
   input  logic                     inDataValid,
   input  logic                     inDataLast,
   output logic                     inDataReady,
   input  logic                     outflag,
   output logic [MEM_DATAWIDTH-1:0] outData,
   output logic                     outDataEnable,
   output logic                     dqs_t,
   output logic                     dqs_c,
   output logic                     writeDataACK,
   output logic                     burstAvail,
   output logic [1:0]               errFlags
);

   localparam int unsigned BIW = $clog2(BURST_LENGTH);
   localparam int unsigned BCW = $clog2(BURST_LENGTH) + 1;
   localparam int unsigned CW  = $clog2(PHYFIFODEPTH / BURST_LENGTH) + 1;
   localparam int unsigned OW  = $clog2(PHYFIFODEPTH) + 1;

   phy_wr_state_t state, next_state;

   logic [MEM_DATAWIDTH-1:0] fifo_data;
   logic [OW-1:0]            occ;
   logic                     push;
   logic                     pop;
   logic [BIW-1:0]           in_idx;
   logic [CW-1:0]            burst_cnt;
   logic [BCW-1:0]           beat_cnt;
   logic                     in_final;
   logic                     burst_done;
   logic                     launch;
   logic                     launch_err;
   logic                     last_err;

   logic [MEM_DATAWIDTH-1:0] data_d;
   logic                     oe_d;
   logic                     dqs_t_d;
   logic                     dqs_c_d;
   logic                     ack_d;

   phy_write_fifo #(
      .WIDTH (MEM_DATAWIDTH),
      .DEPTH (PHYFIFODEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (inData),
      .wr_valid (inDataValid),
      .wr_ready (inDataReady),
      .rd_en    (pop),
      .rd_data  (fifo_data),
      .occ      (occ)
   );

   assign push       = inDataValid & inDataReady;
   assign in_final   = (in_idx == BIW'(BURST_LENGTH - 1));
   assign burst_done = push & in_final;
   assign last_err   = push & (inDataLast != in_final);
   // Launch sees the registered burst count, so a burst completing this
   // same cycle is only launchable from the next cycle.
   assign launch     = outflag & (state == IDLE) & (burst_cnt != '0);
   assign launch_err = outflag & ~launch;
   assign burstAvail = (burst_cnt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         outData       <= '0;
         outDataEnable <= 1'b0;
         dqs_t         <= 1'b0;
         dqs_c         <= 1'b0;
         writeDataACK  <= 1'b0;
         beat_cnt      <= '0;
         in_idx        <= '0;
         burst_cnt     <= '0;
         errFlags      <= '0;
      end else begin
         state         <= next_state;
         outData       <= data_d;
         outDataEnable <= oe_d;
         dqs_t         <= dqs_t_d;
         dqs_c         <= dqs_c_d;
         writeDataACK  <= ack_d;
         beat_cnt      <= pop ? beat_cnt + BCW'(1) : '0;
         if (push) in_idx <= in_idx + BIW'(1);
         burst_cnt     <= burst_cnt + CW'(burst_done) - CW'(launch);
         errFlags[ERR_LAUNCH] <= errFlags[ERR_LAUNCH] | launch_err;
         errFlags[ERR_LAST]   <= errFlags[ERR_LAST] | last_err;
      end
   end

   // beat_cnt counts beats already popped; BURST ends once all are out.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (launch) next_state = PREAMBLE;
         PREAMBLE:  next_state = BURST;
         BURST:     if (beat_cnt == BCW'(BURST_LENGTH)) next_state = POSTAMBLE;
         POSTAMBLE: next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   // Outputs are registered, so they are decoded from next_state.
   always_comb begin
      data_d  = '0;
      oe_d    = 1'b0;
      dqs_t_d = 1'b0;
      dqs_c_d = 1'b0;
      ack_d   = 1'b0;
      pop     = 1'b0;
      case (next_state)
         PREAMBLE: dqs_c_d = 1'b1;
         BURST: begin
            pop     = 1'b1;
            oe_d    = 1'b1;
            data_d  = fifo_data;
            dqs_t_d = ~beat_cnt[0];
            dqs_c_d = beat_cnt[0];
         end
         POSTAMBLE: begin
            dqs_c_d = 1'b1;
            ack_d   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/phy_write_mode.md
Name: phy_write_mode

Overview:
Physical WRITE-mode data transmitter inside the PHYController, the counterpart of the READ capture path. It accepts burst-aligned write data from the Write Buffer and holds it in a PHY-local FIFO. On a PHYController launch pulse it drives one full burst onto the DQ bus with DQS preamble, toggle and postamble, then returns a write-data ACK. It performs no scheduling or timing decisions; the PHYController issues the launch pulse at write latency.

Parameters:
MEM_DATAWIDTH, 64, DQ bus width; comes from MemoryController_Definitions.
BURST_LENGTH, 8, beats per burst; power of two, at least 2.
PHYFIFODEPTH, 16, FIFO depth in beats; an integer multiple of BURST_LENGTH (2 bursts by default).

Ports:
clk  in  1  controller clock; the only clock.
rst  in  1  asynchronous, active-high reset.
inData  in  MEM_DATAWIDTH  write beat from Write Buffer.
inDataValid  in  1  beat valid.
inDataLast  in  1  final beat of a burst.
inDataReady  out  1  FIFO can accept a beat.
outflag  in  1  single-cycle launch pulse from PHYController.
outData  out  MEM_DATAWIDTH  DQ bus drive data.
outDataEnable  out  1  DQ output enable.
dqs_t  out  1  true data strobe.
dqs_c  out  1  complement data strobe.
writeDataACK  out  1  single-cycle pulse after a burst is fully driven.
burstAvail  out  1  at least one complete burst is buffered.
errFlags  out  2  sticky errors: bit0 = launch underrun/overlap; bit1 = LAST misalignment.

Behaviour:
- Reset:
  - rst asserted: all registered outputs go to 0 immediately, FSM returns to IDLE, and pointers and counters clear.
  - A reset mid-burst drops outDataEnable at once and discards all buffered data.
- Push:
  - A push occurs when inDataValid and inDataReady are both high.
  - The beat is written at wptr, which wraps from PHYFIFODEPTH-1 to 0.
  - occ, the beat count, has width clog2(PHYFIFODEPTH)+1.
  - inDataReady = (occ != PHYFIFODEPTH), combinational; it reads 1 during and right after reset.
- Burst counting and LAST check:
  - An input beat index counts 0..BURST_LENGTH-1.
  - A push at index BURST_LENGTH-1 increments burstCnt, which counts complete bursts.
  - If inDataLast does not match (index == BURST_LENGTH-1), set errFlags[1]. The data is still stored and the index still follows the count.
- burstAvail = (burstCnt != 0).
- FSM states: IDLE, PREAMBLE, BURST, POSTAMBLE.
  - IDLE: on outflag with burstCnt > 0, go to PREAMBLE and decrement burstCnt (reservation). On outflag with burstCnt == 0, set errFlags[0] and stay in IDLE.
  - PREAMBLE: one cycle, then BURST.
  - BURST: lasts BURST_LENGTH cycles. Each cycle drives fifo[rptr], increments rptr (with wrap) and decrements occ. After beat BURST_LENGTH-1, go to POSTAMBLE.
  - POSTAMBLE: one cycle with writeDataACK = 1, then IDLE.
  - outflag in any non-IDLE state is ignored and sets errFlags[0].
- Output drive (all outputs registered):
  - IDLE: outDataEnable = 0, outData = 0, dqs_t = 0, dqs_c = 0 (parked).
  - PREAMBLE: dqs_t = 0, dqs_c = 1.
  - BURST: outDataEnable = 1. dqs_t = 1 on even beats and 0 on odd beats; dqs_c = ~dqs_t.
  - POSTAMBLE: dqs_t = 0, dqs_c = 1, outDataEnable = 0.
- Latency, with outflag sampled at cycle T:
  - PREAMBLE outputs at T+1.
  - Beats 0..7 on DQ at T+2..T+9.
  - writeDataACK at T+10.
  - IDLE at T+11, so a new launch is accepted from T+11.
- Simultaneous push and pop in the same cycle is legal: occ stays unchanged.
- A push that completes a burst in the same cycle as an IDLE launch counts toward burstCnt only from the next cycle.
- errFlags are cleared only by rst.

Decomposition:
- The shared package (MemoryController_Definitions) holds:
  - MEM_DATAWIDTH, BURST_LENGTH and PHYFIFODEPTH.
  - The typedef enum phy_wr_state_t {IDLE, PREAMBLE, BURST, POSTAMBLE}.
  - Error bit index constants.
- One sub-module, phy_write_fifo, holds the storage, pointers, occ and inDataReady. The FSM, strobe generation, burstCnt and error logic stay in phy_write_mode.

Test Plan:
- Basic burst: push 8 beats 0xA0..0xA7 with LAST on the 8th, then outflag at T. Expect DQ = 0xA0..0xA7 at T+2..T+9, dqs_t = 1,0,1,0,…, dqs_c = ~dqs_t, writeDataACK for exactly one cycle at T+10, burstAvail = 0 afterward.
- Full FIFO: push 16 beats without launching. inDataReady = 0 with occ = 16, and a 17th valid beat is not accepted. Launch twice back-to-back (the second at T+11) and expect 16 beats out in order, wrapped correctly, with 2 ACKs.
- Concurrent push/pop: stream a third burst while the first is being driven. occ is unchanged on overlapping cycles, and the third burst data is intact on its launch.
- Errors: outflag with an empty FIFO sets errFlags = 2'b01 and leaves the FSM in IDLE. LAST on beat 5 sets errFlags[1]. outflag during BURST is ignored and errFlags[0] stays set.
- Reset mid-burst: assert rst at beat 3. outDataEnable, dqs_t, dqs_c and writeDataACK drop in the same cycle, and occ, burstCnt and errFlags are 0. After release, a fresh burst transmits correctly.
